// File: rtl/aes_pkg.sv
// Shared AES datapath widths and the 128-bit state type.
package aes_pkg;
  localparam int AES_STATE_W = 128;
  localparam int AES_COL_W   = 32;
  localparam int AES_COLS    = 4;

  typedef logic [AES_STATE_W-1:0] state_t;
endpackage

// File: rtl/col_word_packer.sv
// Packs WORDS column words into one AES state; word k lands at out_state[WORD_W*k +: WORD_W].
// Valid/ready on both sides, one word per cycle without bubbles.
module col_word_packer
  import aes_pkg::*;
#(
  parameter int WORD_W = AES_COL_W,
  parameter int WORDS  = AES_COLS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              out_valid,
  input  logic              out_ready,
  output state_t            out_state
);

  localparam int CNT_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int PART_W = WORD_W * (WORDS - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  if (WORD_W * WORDS != AES_STATE_W) begin : g_bad_width
    $error("col_word_packer: WORD_W*WORDS must equal AES_STATE_W");
  end

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PART_W-1:0] part_q, part_d;
  logic              out_valid_q, out_valid_d;
  state_t            out_state_q, out_state_d;

  logic accept, last, fin, consume;

  always_comb begin
    last     = (cnt_q == LAST);
    // Only the final word can be blocked, and only by a held, unconsumed state.
    in_ready = !flush && (!last || !out_valid_q || out_ready);
    accept   = in_valid && in_ready;
    fin      = accept && last;
    consume  = out_valid_q && out_ready;

    cnt_d       = cnt_q;
    part_d      = part_q;
    out_valid_d = out_valid_q;
    out_state_d = out_state_q;

    if (consume) begin
      out_valid_d = 1'b0;
    end

    if (flush) begin
      cnt_d  = '0;
      part_d = '0;
    end else if (fin) begin
      cnt_d       = '0;
      part_d      = '0;
      out_state_d = state_t'({in_word, part_q});
      out_valid_d = 1'b1;
    end else if (accept) begin
      cnt_d = cnt_q + CNT_W'(1);
      for (int i = 0; i < WORDS - 1; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          part_d[i*WORD_W +: WORD_W] = in_word;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      part_q      <= '0;
      out_valid_q <= 1'b0;
      out_state_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      part_q      <= part_d;
      out_valid_q <= out_valid_d;
      out_state_q <= out_state_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;

endmodule

// File: tb/tb_col_word_packer.sv
// Directed bench for col_word_packer with a queue scoreboard of completed states.
module tb_col_word_packer;
  import aes_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  state_t      out_state;

  int checks = 0;
  int errors = 0;

  int          m_cnt;
  logic [31:0] m_w [4];
  state_t      sb_q [$];

  col_word_packer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge: drive, check, advance model, move to next falling edge.
  task automatic cyc(input logic v, input logic [31:0] w, input logic ordy, input logic fl);
    logic exp_rdy;
    in_valid  = v;
    in_word   = w;
    out_ready = ordy;
    flush     = fl;
    #1;
    exp_rdy = !fl && (m_cnt != 3 || sb_q.size() == 0 || ordy);
    chk("in_ready", in_ready, exp_rdy);
    chk("out_valid", out_valid, sb_q.size() != 0);
    if (sb_q.size() != 0) begin
      chk("out_state", out_state, sb_q[0]);
      if (ordy) void'(sb_q.pop_front());
    end
    if (fl) begin
      m_cnt = 0;
    end else if (v && exp_rdy) begin
      m_w[m_cnt] = w;
      if (m_cnt == 3) begin
        sb_q.push_back({w, m_w[2], m_w[1], m_w[0]});
        m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_word = '0; out_ready = 1'b0;
    m_cnt = 0;
    repeat (3) @(negedge clk);
    // 1. reset
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_state", out_state, '0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);

    // 2. single stream
    cyc(1, 32'h03020100, 1, 0);
    cyc(1, 32'h07060504, 1, 0);
    cyc(1, 32'h0B0A0908, 1, 0);
    cyc(1, 32'h0F0E0D0C, 1, 0);
    #1;
    chk("t2_valid", out_valid, 1'b1);
    chk("t2_state", out_state, 128'h0F0E0D0C_0B0A0908_07060504_03020100);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // 3. back-to-back, 8 words
    for (int i = 0; i < 8; i++) cyc(1, 32'h1000_0000 + 32'(i * 32'h0101_0101), 1, 0);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    // 4. backpressure: A held, B's fourth word stalls then merges on the consume edge
    for (int i = 0; i < 4; i++) cyc(1, 32'hA000_0000 + 32'(i), 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hB000_0000 + 32'(i), 0, 0);
    cyc(1, 32'hB000_0003, 0, 0);
    cyc(1, 32'hB000_0003, 0, 0);
    cyc(1, 32'hB000_0003, 1, 0);
    #1;
    chk("t4_valid_kept", out_valid, 1'b1);
    chk("t4_state_b", out_state, 128'hB000_0003_B000_0002_B000_0001_B000_0000);
    cyc(0, 32'h0, 1, 0);

    // 5. flush with a pending state held
    for (int i = 0; i < 4; i++) cyc(1, 32'hC000_0000 + 32'(i), 0, 0);
    cyc(1, 32'hDEAD_0000, 0, 0);
    cyc(1, 32'hDEAD_0001, 0, 0);
    cyc(1, 32'hDEAD_0002, 0, 1);
    cyc(0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) cyc(1, 32'hE000_0000 + 32'(i), 0, 0);
    cyc(1, 32'hE000_0003, 1, 0);
    #1;
    chk("t5_clean_state", out_state, 128'hE000_0003_E000_0002_E000_0001_E000_0000);
    cyc(0, 32'h0, 1, 0);

    // 6. async reset mid-state with a pending output
    for (int i = 0; i < 4; i++) cyc(1, 32'h5000_0000 + 32'(i), 0, 0);
    cyc(1, 32'h6000_0000, 0, 0);
    cyc(1, 32'h6000_0001, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_valid", out_valid, 1'b0);
    chk("t6_async_state", out_state, '0);
    sb_q.delete();
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) cyc(1, 32'h7000_0000 + 32'(i), 0, 0);
    #1;
    chk("t6_fresh_state", out_state, 128'h7000_0003_7000_0002_7000_0001_7000_0000);
    cyc(0, 32'h0, 1, 0);
    cyc(0, 32'h0, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
